// File: rtl/qdec_cabac_regbank_pkg.sv
// ============================================================================
// Package : qdec_cabac_package
// Brief   : Register map, bus structs and status layout for the CABAC regbank.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package qdec_cabac_package;

    localparam int REG_AW = 12;

    localparam logic [REG_AW-1:0] ADDR_CABAC_CTRL     = 12'h000;
    localparam logic [REG_AW-1:0] ADDR_CABAC_STATUS   = 12'h004;
    localparam logic [REG_AW-1:0] ADDR_CABAC_IRQ_EN   = 12'h008;
    localparam logic [REG_AW-1:0] ADDR_CABAC_FCNT     = 12'h00C;
    localparam logic [REG_AW-1:0] ADDR_CABAC_CFG_BASE = 12'h010;

    localparam logic [31:0] REG_BAD_DATA = 32'hBADC_AB0C;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_DONE_BIT    = 1;
    localparam int STATUS_ERROR_BIT   = 2;
    localparam int STATUS_OVERRUN_BIT = 3;

    typedef struct packed {
        logic              wr_en;
        logic [REG_AW-1:0] addr_wr;
        logic [31:0]       hwdata;
        logic [REG_AW-1:0] addr_rd;
    } t_reg_req_s;

    typedef struct packed {
        logic [31:0] rdata;
    } t_reg_resp_s;

    typedef struct packed {
        logic [27:0] rsvd;
        logic        overrun;
        logic        error;
        logic        done;
        logic        busy;
    } t_reg_CABAC_STATUS_s;

    function automatic logic [REG_AW-1:0] cfg_addr(input int idx);
        return ADDR_CABAC_CFG_BASE + REG_AW'(idx * 4);
    endfunction

endpackage

`default_nettype wire

// File: rtl/qdec_reg_sticky_bit.sv
// ============================================================================
// Module : qdec_reg_sticky_bit
// Brief  : Sticky status bit; hardware set beats a simultaneous W1C clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module qdec_reg_sticky_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic hw_set,
    input  logic w1c_clr,
    output logic q
);

    logic bit_d;
    logic bit_q;

    always_comb begin
        bit_d = bit_q;
        if (hw_set) begin
            bit_d = 1'b1;
        end else if (w1c_clr) begin
            bit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q = bit_q;

endmodule

`default_nettype wire

// File: rtl/qdec_cabac_regbank.sv
// ============================================================================
// Module : qdec_cabac_regbank
// Brief  : CABAC control/status register bank with start-time config snapshot.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module qdec_cabac_regbank
    import qdec_cabac_package::*;
#(
    parameter int               NUM_CFG  = 6,
    parameter logic [16*32-1:0] CFG_MASK = {16{32'hffffffff}},
    parameter int               FCNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  t_reg_req_s           reg_req,
    output t_reg_resp_s          reg_resp,
    input  logic                 cabac_done,
    input  logic                 cabac_error,
    output logic                 cabac_start,
    output logic                 cabac_busy,
    output logic [NUM_CFG*32-1:0] cfg_live,
    output logic [NUM_CFG*32-1:0] cfg_active,
    output logic                 irq
);

    logic              wr_en;
    logic [REG_AW-1:0] reg_addr_wr;
    logic [31:0]       reg_req_hwdata;
    logic [REG_AW-1:0] reg_addr_rd;
    logic [31:0]       pre_rdata;

    assign wr_en          = reg_req.wr_en;
    assign reg_addr_wr    = reg_req.addr_wr;
    assign reg_req_hwdata = reg_req.hwdata;
    assign reg_addr_rd    = reg_req.addr_rd;

    logic              busy_d,   busy_q;
    logic              start_d,  start_q;
    logic              irq_d,    irq_q;
    logic [2:0]        irq_en_d, irq_en_q;
    logic [FCNT_W-1:0] fcnt_d,   fcnt_q;
    logic              done_st, error_st, overrun_st;
    logic [31:0]       cfg_live_q [NUM_CFG];

    logic wr_start, start_acc, start_rej, w1c;
    logic hw_done, hw_error;

    assign wr_start  = wr_en && (reg_addr_wr == ADDR_CABAC_CTRL) && reg_req_hwdata[0];
    assign start_acc = wr_start && !busy_q;
    assign start_rej = wr_start && busy_q;
    assign w1c       = wr_en && (reg_addr_wr == ADDR_CABAC_STATUS);
    // Error dominates a coincident done; both ignored when idle.
    assign hw_error  = busy_q && cabac_error;
    assign hw_done   = busy_q && cabac_done && !cabac_error;

    always_comb begin
        busy_d   = busy_q;
        start_d  = start_acc;
        fcnt_d   = fcnt_q;
        irq_en_d = irq_en_q;
        if (start_acc) begin
            busy_d = 1'b1;
        end else if (hw_done || hw_error) begin
            busy_d = 1'b0;
        end
        if (hw_done) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end
        if (wr_en && (reg_addr_wr == ADDR_CABAC_IRQ_EN)) begin
            irq_en_d = reg_req_hwdata[2:0];
        end
        irq_d = |({overrun_st, error_st, done_st} & irq_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
            irq_en_q <= 3'b000;
            fcnt_q   <= '0;
        end else begin
            busy_q   <= busy_d;
            start_q  <= start_d;
            irq_q    <= irq_d;
            irq_en_q <= irq_en_d;
            fcnt_q   <= fcnt_d;
        end
    end

    qdec_reg_sticky_bit u_done (
        .clk     (clk),
        .rst_n   (rst_n),
        .hw_set  (hw_done),
        .w1c_clr (w1c && reg_req_hwdata[STATUS_DONE_BIT]),
        .q       (done_st)
    );

    qdec_reg_sticky_bit u_error (
        .clk     (clk),
        .rst_n   (rst_n),
        .hw_set  (hw_error),
        .w1c_clr (w1c && reg_req_hwdata[STATUS_ERROR_BIT]),
        .q       (error_st)
    );

    qdec_reg_sticky_bit u_overrun (
        .clk     (clk),
        .rst_n   (rst_n),
        .hw_set  (start_rej),
        .w1c_clr (w1c && reg_req_hwdata[STATUS_OVERRUN_BIT]),
        .q       (overrun_st)
    );

    generate
        for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
            logic [31:0] live_d;
            logic [31:0] active_d, active_q;

            always_comb begin
                live_d   = cfg_live_q[i];
                active_d = start_acc ? cfg_live_q[i] : active_q;
                if (wr_en && (reg_addr_wr == cfg_addr(i))) begin
                    live_d = reg_req_hwdata & CFG_MASK[32*i +: 32];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cfg_live_q[i] <= '0;
                    active_q      <= '0;
                end else begin
                    cfg_live_q[i] <= live_d;
                    active_q      <= active_d;
                end
            end

            assign cfg_live[32*i +: 32]   = cfg_live_q[i];
            assign cfg_active[32*i +: 32] = active_q;
        end
    endgenerate

    t_reg_CABAC_STATUS_s status;

    always_comb begin
        status         = '0;
        status.busy    = busy_q;
        status.done    = done_st;
        status.error   = error_st;
        status.overrun = overrun_st;
    end

    always_comb begin
        pre_rdata = REG_BAD_DATA;
        case (reg_addr_rd)
            ADDR_CABAC_CTRL:   pre_rdata = '0;
            ADDR_CABAC_STATUS: pre_rdata = status;
            ADDR_CABAC_IRQ_EN: pre_rdata = {29'd0, irq_en_q};
            ADDR_CABAC_FCNT:   pre_rdata = 32'(fcnt_q);
            default:           pre_rdata = REG_BAD_DATA;
        endcase
        for (int i = 0; i < NUM_CFG; i++) begin
            if (reg_addr_rd == cfg_addr(i)) begin
                pre_rdata = cfg_live_q[i];
            end
        end
    end

    assign reg_resp.rdata = pre_rdata;
    assign cabac_start    = start_q;
    assign cabac_busy     = busy_q;
    assign irq            = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_qdec_cabac_regbank.sv
// ============================================================================
// Module : tb_qdec_cabac_regbank
// Brief  : Scoreboard bench for qdec_cabac_regbank (directed vectors).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_qdec_cabac_regbank;
    import qdec_cabac_package::*;

    localparam int NCFG = 6;
    localparam logic [16*32-1:0] MASK = {{13{32'hffffffff}}, 32'h07ffffff,
                                         32'hffffffff, 32'hffffffff};
    localparam int FW = 2;

    localparam int K_RD    = 0;
    localparam int K_START = 1;
    localparam int K_BUSY  = 2;
    localparam int K_IRQ   = 3;
    localparam int K_ACT   = 4;
    localparam int K_LIVE  = 5;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] val;
    } t_exp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    t_reg_req_s  reg_req;
    t_reg_resp_s reg_resp;
    logic cabac_done, cabac_error, cabac_start, cabac_busy, irq;
    logic [NCFG*32-1:0] cfg_live, cfg_active;

    t_exp sb[$];
    logic obs_valid = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    qdec_cabac_regbank #(
        .NUM_CFG  (NCFG),
        .CFG_MASK (MASK),
        .FCNT_W   (FW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg_req     (reg_req),
        .reg_resp    (reg_resp),
        .cabac_done  (cabac_done),
        .cabac_error (cabac_error),
        .cabac_start (cabac_start),
        .cabac_busy  (cabac_busy),
        .cfg_live    (cfg_live),
        .cfg_active  (cfg_active),
        .irq         (irq)
    );

    // Monitor: drains every queued expectation when the bench flags an observation.
    always @(negedge clk) begin
        t_exp        e;
        logic [31:0] act;
        if (obs_valid) begin
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    K_RD:    act = reg_resp.rdata;
                    K_START: act = {31'd0, cabac_start};
                    K_BUSY:  act = {31'd0, cabac_busy};
                    K_IRQ:   act = {31'd0, irq};
                    K_ACT:   act = cfg_active[32*e.idx +: 32];
                    default: act = cfg_live[32*e.idx +: 32];
                endcase
                n_cmp++;
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int kind, input int idx, input logic [31:0] val, input string name);
        t_exp e;
        e.name = name;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic sample();
        obs_valid = 1'b1;
        @(negedge clk);
        #1;
        obs_valid = 1'b0;
    endtask

    task automatic rd(input logic [REG_AW-1:0] addr, input logic [31:0] val, input string name);
        reg_req.addr_rd = addr;
        chk(K_RD, 0, val, name);
        sample();
    endtask

    task automatic wr(input logic [REG_AW-1:0] addr, input logic [31:0] data);
        reg_req.wr_en   = 1'b1;
        reg_req.addr_wr = addr;
        reg_req.hwdata  = data;
        tick();
        reg_req.wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        cabac_done = 1'b1;
        tick();
        cabac_done = 1'b0;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        reg_req     = '0;
        cabac_done  = 1'b0;
        cabac_error = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state and unmapped read
        for (int a = 0; a < 'h28; a += 4) rd(REG_AW'(a), 32'h0, "rst_read");
        chk(K_START, 0, 0, "rst_start");
        chk(K_BUSY, 0, 0, "rst_busy");
        chk(K_IRQ, 0, 0, "rst_irq");
        rd(12'h040, REG_BAD_DATA, "unmapped_read");

        // Masking and read-only counter
        wr(ADDR_CABAC_CFG_BASE + 12'h8, 32'hFFFF_FFFF);
        rd(ADDR_CABAC_CFG_BASE + 12'h8, 32'h07FF_FFFF, "cfg2_mask");
        wr(ADDR_CABAC_FCNT, 32'h1);
        rd(ADDR_CABAC_FCNT, 32'h0, "fcnt_ro");

        // Start and snapshot
        wr(ADDR_CABAC_CFG_BASE, 32'hA5);
        wr(ADDR_CABAC_CTRL, 32'h1);
        chk(K_START, 0, 1, "start_pulse");
        chk(K_BUSY, 0, 1, "busy_set");
        chk(K_ACT, 0, 32'hA5, "snap_cfg0");
        chk(K_ACT, 2, 32'h07FF_FFFF, "snap_cfg2");
        rd(ADDR_CABAC_CTRL, 32'h0, "ctrl_reads0");
        tick();
        chk(K_START, 0, 0, "start_one_cycle");
        sample();
        wr(ADDR_CABAC_CFG_BASE, 32'h5A);
        chk(K_ACT, 0, 32'hA5, "active_held");
        chk(K_LIVE, 0, 32'h5A, "live_updated");
        sample();

        // Overrun and interrupt
        wr(ADDR_CABAC_CTRL, 32'h1);
        chk(K_START, 0, 0, "no_pulse_busy");
        rd(ADDR_CABAC_STATUS, 32'h9, "overrun_status");
        wr(ADDR_CABAC_IRQ_EN, 32'h4);
        chk(K_IRQ, 0, 0, "irq_lag");
        rd(ADDR_CABAC_IRQ_EN, 32'h4, "irq_en_rd");
        tick();
        chk(K_IRQ, 0, 1, "irq_set");
        sample();
        wr(ADDR_CABAC_STATUS, 32'h8);
        rd(ADDR_CABAC_STATUS, 32'h1, "w1c_overrun");
        tick();
        chk(K_IRQ, 0, 0, "irq_clear");
        sample();

        // Done, done+error, counter wrap
        pulse_done();
        chk(K_BUSY, 0, 0, "done_busy");
        rd(ADDR_CABAC_STATUS, 32'h2, "done_status");
        rd(ADDR_CABAC_FCNT, 32'h1, "fcnt_1");
        wr(ADDR_CABAC_CTRL, 32'h1);
        chk(K_BUSY, 0, 1, "pic2_busy");
        sample();
        cabac_done  = 1'b1;
        cabac_error = 1'b1;
        tick();
        cabac_done  = 1'b0;
        cabac_error = 1'b0;
        rd(ADDR_CABAC_STATUS, 32'h6, "done_err_status");
        rd(ADDR_CABAC_FCNT, 32'h1, "err_fcnt_held");
        wr(ADDR_CABAC_STATUS, 32'h6);
        rd(ADDR_CABAC_STATUS, 32'h0, "w1c_all");
        for (int p = 0; p < 3; p++) begin
            wr(ADDR_CABAC_CTRL, 32'h1);
            if (p < 2) begin
                pulse_done();
            end else begin
                cabac_done = 1'b1;
                wr(ADDR_CABAC_STATUS, 32'h2);
                cabac_done = 1'b0;
            end
        end
        rd(ADDR_CABAC_STATUS, 32'h2, "set_wins");
        rd(ADDR_CABAC_FCNT, 32'h0, "fcnt_wrap");

        // Start in the same cycle as done
        wr(ADDR_CABAC_CTRL, 32'h1);
        cabac_done = 1'b1;
        wr(ADDR_CABAC_CTRL, 32'h1);
        cabac_done = 1'b0;
        chk(K_START, 0, 0, "start_vs_done_pulse");
        chk(K_BUSY, 0, 0, "start_vs_done_busy");
        rd(ADDR_CABAC_STATUS, 32'hA, "start_vs_done_status");
        rd(ADDR_CABAC_FCNT, 32'h1, "fcnt_after_wrap");

        // Asynchronous reset mid-picture
        wr(ADDR_CABAC_IRQ_EN, 32'h7);
        wr(ADDR_CABAC_CTRL, 32'h1);
        tick();
        chk(K_BUSY, 0, 1, "pre_rst_busy");
        chk(K_IRQ, 0, 1, "pre_rst_irq");
        sample();
        tick();
        rst_n = 1'b0;
        chk(K_BUSY, 0, 0, "async_rst_busy");
        chk(K_IRQ, 0, 0, "async_rst_irq");
        chk(K_ACT, 0, 32'h0, "async_rst_active");
        rd(ADDR_CABAC_STATUS, 32'h0, "async_rst_status");
        tick();
        rst_n = 1'b1;
        tick();
        pulse_done();
        chk(K_BUSY, 0, 0, "post_rst_busy");
        rd(ADDR_CABAC_STATUS, 32'h0, "post_rst_done_ignored");
        rd(ADDR_CABAC_FCNT, 32'h0, "post_rst_fcnt");

        tick();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qdec_cabac_regbank.md
# qdec_cabac_regbank

Parametrised control/status register bank for the CABAC decoder, sitting between the AXI register front-end and the CABAC core. It holds NUM_CFG masked configuration words and snapshots them into an active copy on each accepted start, so software can program the next picture while the current one decodes. It tracks busy, done and error state with write-1-to-clear status bits, counts completed pictures, and drives a maskable interrupt.

## Interface
- NUM_CFG, 6: number of 32-bit configuration registers (1..16).
- CFG_MASK, {16{32'hffffffff}}: per-register writable-bit mask; entry i applies to CFG[i].
- FCNT_W, 16: picture counter width (1..32).
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- reg_req  in  t_reg_req_s  register bus request.
- reg_resp  out  t_reg_resp_s  register bus response.
- cabac_done  in  1  one-cycle pulse: picture finished.
- cabac_error  in  1  one-cycle pulse: picture aborted on error.
- cabac_start  out  1  one-cycle start pulse to the core.
- cabac_busy  out  1  the core owns the active configuration.
- cfg_live  out  NUM_CFG*32  programmed values; word i at [32i+31:32i].
- cfg_active  out  NUM_CFG*32  snapshot taken at the last accepted start.
- irq  out  1  level interrupt.

## Operation
- Bus decode goes through the shared register front-end: wr_en, reg_addr_wr, reg_req_hwdata for writes; reg_addr_rd selects pre_rdata for reads. Unmapped reads return REG_BAD_DATA. Writes to unmapped or read-only addresses are ignored.
- Register map, as byte offsets:
  - 0x00 CTRL: bit0 start, write-1 only; reads 0.
  - 0x04 STATUS: bit0 busy (RO), bit1 done, bit2 error, bit3 overrun. Bits 3:1 are W1C.
  - 0x08 IRQ_EN: bits 2:0 enable done, error and overrun; bits 31:3 read 0.
  - 0x0C FCNT: read-only picture counter.
  - 0x10+4i CFG[i]: read/write, value stored as hwdata & CFG_MASK[i].
- Start write with busy=0:
  - accepted;
  - next edge: cabac_start=1 for exactly one cycle, busy←1, cfg_active←cfg_live.
  - The value written to CFG in that same cycle is not yet in cfg_live, so it is not snapshotted.
- Start write with busy=1: rejected; overrun←1; no pulse; cfg_active unchanged.
- cabac_done while busy: busy←0, done←1, FCNT←FCNT+1, wrapping from all-ones to 0.
- cabac_error while busy: busy←0, error←1; FCNT unchanged.
- Both done and error in the same cycle: treated as error only.
- done or error while busy=0: ignored.
- Start write in the same cycle as done/error: rejected as overrun, because busy is still 1 in that cycle.
- A hardware set and a W1C on the same status bit in the same cycle: the set wins.
- irq ← |(STATUS[3:1] & IRQ_EN[2:0]), registered.

## Timing
- Reset values: all registers, cfg_live and cfg_active are 0; cabac_start, cabac_busy and irq are 0.
- Reset asserted mid-picture clears busy immediately (asynchronously); any done pulse arriving after release is ignored.
- Write to observable effect: 1 cycle for CFG, STATUS and the start pulse.
- irq lags the status/enable change by 1 cycle.
- Read latency is set by the front-end: pre_rdata is combinational from the current register state.
- cabac_busy equals STATUS.busy with no extra delay.

## Structure
- Goes in qdec_cabac_package:
  - address constants ADDR_CABAC_CTRL, ADDR_CABAC_STATUS, ADDR_CABAC_IRQ_EN, ADDR_CABAC_FCNT, ADDR_CABAC_CFG_BASE;
  - STATUS bit-index constants;
  - t_reg_CABAC_STATUS_s.
- Sub-module qdec_reg_sticky_bit, instantiated three times: one sticky status bit with a hardware-set input, a W1C input and a set-wins rule.
- The CFG array and its write decode are generated over NUM_CFG.

## Test plan
- Reset, then read every mapped address → all 0. Read 0x40 with NUM_CFG=6 → REG_BAD_DATA.
- Write CFG[2]=0xFFFFFFFF with mask 0x07FFFFFF → reads back 0x07FFFFFF. Write 0x1 to 0x0C → FCNT stays 0.
- Program CFG[0]=0xA5, write CTRL=1 → one-cycle cabac_start, busy=1, cfg_active[0]=0xA5. Then write CFG[0]=0x5A → cfg_active stays 0xA5, cfg_live=0x5A.
- While busy, write CTRL=1 → no pulse, STATUS=0x9. Set IRQ_EN=0x4 → irq=1 one cycle later. W1C 0x8 → irq=0.
- Pulse cabac_done → STATUS=0x2, FCNT=1. Pulse done and error together on the next picture → STATUS=0x6, FCNT stays 1. FCNT_W=2 with 4 done pictures → FCNT wraps to 0.
- Assert rst_n low mid-picture → busy and irq drop immediately. Pulse done after release → ignored, STATUS=0.
